// File: rtl/mmcm_lock_supervisor.sv
// MMCM reset sequencer and lock qualifier in the 40 MHz reference domain.
// Holds downstream logic in reset until lock is stable and retries on timeout or lock loss.
module mmcm_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk40m_i,
  input  logic       reset_n,
  input  logic       locked_i,
  input  logic       clear_i,
  output logic       mmcm_reset_o,
  output logic       sys_reset_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic       fail_o,
  output logic [7:0] relock_cnt_o
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_MMCM  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               locked_meta_q, locked_s_q;
  logic               lock_loss;
  logic               mmcm_reset_d, sys_reset_n_d, ready_d, lock_lost_d, fail_d;
  logic [7:0]         relock_cnt_d, relock_base;

  // Two-flop synchronizer: the only consumer of the asynchronous LOCKED input.
  always_ff @(posedge clk40m_i or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked_i;
      locked_s_q    <= locked_meta_q;
    end
  end

  // Next-state, timer and retry bookkeeping.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    lock_loss = 1'b0;
    unique case (state_q)
      ST_RST_MMCM: begin
        if (timer_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST_MMCM;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s_q) begin
          state_d = ST_RST_MMCM;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s_q) begin
          state_d   = ST_RST_MMCM;
          timer_d   = '0;
          lock_loss = 1'b1;
        end
      end
      ST_FAIL: begin
        if (clear_i) begin
          state_d = ST_RST_MMCM;
          timer_d = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_RST_MMCM;
        timer_d = '0;
      end
    endcase
  end

  // Outputs follow the next state so they line up with the registered state.
  always_comb begin
    mmcm_reset_d  = (state_d == ST_RST_MMCM) || (state_d == ST_FAIL);
    sys_reset_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
    // A lock-loss event in the same cycle as clear wins over the clear.
    relock_base   = clear_i ? 8'd0 : relock_cnt_o;
    relock_cnt_d  = relock_base;
    lock_lost_d   = clear_i ? 1'b0 : lock_lost_o;
    if (lock_loss) begin
      lock_lost_d = 1'b1;
      if (relock_base != 8'hFF) begin
        relock_cnt_d = relock_base + 8'd1;
      end
    end
  end

  always_ff @(posedge clk40m_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST_MMCM;
      timer_q       <= '0;
      retry_q       <= '0;
      mmcm_reset_o  <= 1'b1;
      sys_reset_n_o <= 1'b0;
      ready_o       <= 1'b0;
      lock_lost_o   <= 1'b0;
      fail_o        <= 1'b0;
      relock_cnt_o  <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      mmcm_reset_o  <= mmcm_reset_d;
      sys_reset_n_o <= sys_reset_n_d;
      ready_o       <= ready_d;
      lock_lost_o   <= lock_lost_d;
      fail_o        <= fail_d;
      relock_cnt_o  <= relock_cnt_d;
    end
  end

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Self-checking bench for mmcm_lock_supervisor: vector table, directed corner sequences,
// and randomized LOCKED/clear traffic against a phase/age reference model.
module tb_mmcm_lock_supervisor;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned MAX_RETRY     = 2;

  logic       clk;
  logic       reset_n;
  logic       locked_i;
  logic       clear_i;
  logic       mmcm_reset_o;
  logic       sys_reset_n_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic       fail_o;
  logic [7:0] relock_cnt_o;

  int total = 0;
  int bad   = 0;
  bit sys_hi;

  mmcm_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clk40m_i     (clk),
    .reset_n      (reset_n),
    .locked_i     (locked_i),
    .clear_i      (clear_i),
    .mmcm_reset_o (mmcm_reset_o),
    .sys_reset_n_o(sys_reset_n_o),
    .ready_o      (ready_o),
    .lock_lost_o  (lock_lost_o),
    .fail_o       (fail_o),
    .relock_cnt_o (relock_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mmcm_reset, sys_reset_n, ready, lock_lost, fail, relock_cnt}
  function automatic logic [12:0] outv(input logic m, input logic s, input logic r,
                                       input logic l, input logic f, input logic [7:0] c);
    return {m, s, r, l, f, c};
  endfunction

  function automatic logic [12:0] dut_out();
    return {mmcm_reset_o, sys_reset_n_o, ready_o, lock_lost_o, fail_o, relock_cnt_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (sys_reset_n_o) sys_hi = 1'b1;
  endtask

  task automatic check_vec(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got m=%b s=%b r=%b l=%b f=%b c=%0d want m=%b s=%b r=%b l=%b f=%b c=%0d",
               name, act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Waits for a chosen output (0 mmcm_reset, 1 sys_reset_n, 2 fail) to reach lvl.
  task automatic wait_sig(input int sel, input logic lvl, input int budget,
                          input string name, output int n);
    logic v;
    bit   hit;
    n   = 0;
    hit = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (sel)
        0:       v = mmcm_reset_o;
        1:       v = sys_reset_n_o;
        default: v = fail_o;
      endcase
      hit = (v == lvl);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s: level %0b not reached, got %0b after %0d cycles", name, lvl, v, budget);
    end
  endtask

  task automatic do_reset(input logic lk);
    reset_n  = 1'b0;
    locked_i = lk;
    clear_i  = 1'b0;
    tick();
    tick();
    check_vec("reset_state", dut_out(), outv(1, 0, 0, 0, 0, 8'd0));
    reset_n = 1'b1;
  endtask

  task automatic lose_and_relock(input string name);
    int n;
    locked_i = 1'b0;
    wait_sig(1, 1'b0, 6, {name, "_fall"}, n);
    locked_i = 1'b1;
    wait_sig(1, 1'b1, 40, {name, "_rise"}, n);
  endtask

  // Reference model: phase plus cycles-in-phase, LOCKED seen through a 2-deep queue.
  localparam int PH_RESETTING = 0, PH_WAITING = 1, PH_QUALIFYING = 2, PH_RUNNING = 3, PH_FAILED = 4;
  int m_phase, m_age, m_fails, m_cnt;
  bit m_lost;
  bit m_pipe[$];

  function automatic void m_reset();
    m_phase = PH_RESETTING;
    m_age   = 0;
    m_fails = 0;
    m_lost  = 0;
    m_cnt   = 0;
    m_pipe.delete();
    m_pipe.push_back(1'b0);
    m_pipe.push_back(1'b0);
  endfunction

  function automatic void m_enter(input int ph);
    m_phase = ph;
    m_age   = 0;
  endfunction

  function automatic void m_step(input bit lk, input bit clr);
    bit ls, loss;
    ls = m_pipe.pop_front();
    m_pipe.push_back(lk);
    loss = 0;
    m_age++;
    case (m_phase)
      PH_RESETTING: if (m_age == int'(RST_CYCLES)) m_enter(PH_WAITING);
      PH_WAITING: begin
        if (ls) m_enter(PH_QUALIFYING);
        else if (m_age == int'(LOCK_TIMEOUT)) begin
          if (m_fails == int'(MAX_RETRY)) m_enter(PH_FAILED);
          else begin
            m_fails++;
            m_enter(PH_RESETTING);
          end
        end
      end
      PH_QUALIFYING: begin
        if (!ls) m_enter(PH_RESETTING);
        else if (m_age == int'(STABLE_CYCLES)) begin
          m_fails = 0;
          m_enter(PH_RUNNING);
        end
      end
      PH_RUNNING: if (!ls) begin
        loss = 1;
        m_enter(PH_RESETTING);
      end
      default: if (clr) begin
        m_fails = 0;
        m_enter(PH_RESETTING);
      end
    endcase
    if (clr) begin
      m_lost = 0;
      m_cnt  = 0;
    end
    if (loss) begin
      m_lost = 1;
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  endfunction

  function automatic logic [12:0] m_out();
    return outv(m_phase == PH_RESETTING || m_phase == PH_FAILED, m_phase == PH_RUNNING,
                m_phase == PH_RUNNING, m_lost, m_phase == PH_FAILED, 8'(m_cnt));
  endfunction

  typedef struct {
    logic        rst_n;
    logic        locked;
    logic        clear;
    int          cycles;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic lk, input logic c, input int n,
                              input logic [12:0] e);
    vec_t v;
    v.rst_n  = r;
    v.locked = lk;
    v.clear  = c;
    v.cycles = n;
    v.exp    = e;
    return v;
  endfunction

  initial begin
    int  n, n2, windows;
    bit  lk, clr;
    int  run_left;

    reset_n  = 1'b0;
    locked_i = 1'b0;
    clear_i  = 1'b0;
    sys_hi   = 1'b0;
    @(negedge clk);

    // Timeout/fail/clear script with locked held low; cycle counts are from reset release.
    tbl[0]  = mk(0, 0, 0, 2,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[1]  = mk(1, 0, 0, 3,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[2]  = mk(1, 0, 0, 1,  outv(0, 0, 0, 0, 0, 8'd0));
    tbl[3]  = mk(1, 0, 0, 19, outv(0, 0, 0, 0, 0, 8'd0));
    tbl[4]  = mk(1, 0, 0, 1,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[5]  = mk(1, 0, 0, 3,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[6]  = mk(1, 0, 0, 1,  outv(0, 0, 0, 0, 0, 8'd0));
    tbl[7]  = mk(1, 0, 0, 20, outv(1, 0, 0, 0, 0, 8'd0));
    tbl[8]  = mk(1, 0, 0, 4,  outv(0, 0, 0, 0, 0, 8'd0));
    tbl[9]  = mk(1, 0, 0, 19, outv(0, 0, 0, 0, 0, 8'd0));
    tbl[10] = mk(1, 0, 0, 1,  outv(1, 0, 0, 0, 1, 8'd0));
    tbl[11] = mk(1, 0, 0, 30, outv(1, 0, 0, 0, 1, 8'd0));
    tbl[12] = mk(1, 0, 1, 1,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[13] = mk(1, 0, 0, 3,  outv(1, 0, 0, 0, 0, 8'd0));
    tbl[14] = mk(1, 0, 0, 1,  outv(0, 0, 0, 0, 0, 8'd0));
    tbl[15] = mk(1, 0, 0, 20, outv(1, 0, 0, 0, 0, 8'd0));
    for (int i = 0; i < 16; i++) begin
      reset_n  = tbl[i].rst_n;
      locked_i = tbl[i].locked;
      clear_i  = tbl[i].clear;
      for (int k = 0; k < tbl[i].cycles; k++) tick();
      check_vec($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    clear_i = 1'b0;

    // Normal bring-up: locked sampled 5 edges after mmcm_reset falls.
    do_reset(1'b0);
    wait_sig(0, 1'b0, 10, "bringup_rst", n);
    check_int("bringup_rst_len", n, 4);
    for (int k = 0; k < 4; k++) tick();
    locked_i = 1'b1;
    wait_sig(1, 1'b1, 30, "bringup_run", n2);
    check_int("bringup_latency", 4 + n2, 15);
    check_vec("bringup_run_out", dut_out(), outv(0, 1, 1, 0, 0, 8'd0));

    // Glitch in STABLE after one prior timeout; retry count must stay at 1.
    do_reset(1'b0);
    wait_sig(0, 1'b0, 10, "gl_w1", n);
    wait_sig(0, 1'b1, 30, "gl_to1", n);
    wait_sig(0, 1'b0, 10, "gl_w2", n);
    sys_hi   = 1'b0;
    locked_i = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    locked_i = 1'b0;
    tick();
    locked_i = 1'b1;
    wait_sig(0, 1'b1, 6, "gl_rst_rise", n);
    locked_i = 1'b0;
    wait_sig(0, 1'b0, 10, "gl_rst_fall", n);
    check_int("gl_rst_len", n, 4);
    check_int("gl_no_sys", int'(sys_hi), 0);
    windows = 0;
    for (int w = 0; w < 4 && !fail_o; w++) begin
      wait_sig(0, 1'b1, 30, "gl_window", n);
      windows++;
      if (!fail_o) wait_sig(0, 1'b0, 10, "gl_rewait", n);
    end
    check_int("gl_windows_to_fail", windows, 2);
    check_int("gl_no_sys_end", int'(sys_hi), 0);

    // Lock loss in RUN, then 299 more to saturate the counter.
    do_reset(1'b1);
    wait_sig(1, 1'b1, 40, "loss_up", n);
    locked_i = 1'b0;
    wait_sig(1, 1'b0, 6, "loss_fall", n);
    check_int("loss_latency_ok", int'(n >= 2 && n <= 3), 1);
    check_vec("loss_out", dut_out(), outv(1, 0, 0, 1, 0, 8'd1));
    locked_i = 1'b1;
    wait_sig(1, 1'b1, 40, "loss_relock", n);
    check_vec("relock_out", dut_out(), outv(0, 1, 1, 1, 0, 8'd1));
    for (int i = 2; i <= 300; i++) begin
      lose_and_relock("sat");
      if (i == 254) check_int("cnt_254", int'(relock_cnt_o), 254);
    end
    check_vec("sat_out", dut_out(), outv(0, 1, 1, 1, 0, 8'd255));

    // Clear coinciding with the lock-loss edge, then a lone clear.
    do_reset(1'b1);
    wait_sig(1, 1'b1, 40, "col_up", n);
    lose_and_relock("col_a");
    lose_and_relock("col_b");
    check_vec("col_pre", dut_out(), outv(0, 1, 1, 1, 0, 8'd2));
    locked_i = 1'b0;
    tick();
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_vec("col_edge", dut_out(), outv(1, 0, 0, 1, 0, 8'd1));
    locked_i = 1'b1;
    wait_sig(1, 1'b1, 40, "col_relock", n);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_vec("lone_clear", dut_out(), outv(0, 1, 1, 0, 0, 8'd0));
    for (int k = 0; k < 5; k++) tick();
    check_vec("lone_clear_hold", dut_out(), outv(0, 1, 1, 0, 0, 8'd0));

    // Asynchronous reset pulse mid-RUN.
    lose_and_relock("ar_pre");
    check_vec("ar_pre_out", dut_out(), outv(0, 1, 1, 1, 0, 8'd1));
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_vec("ar_immediate", dut_out(), outv(1, 0, 0, 0, 0, 8'd0));
    @(negedge clk);
    reset_n = 1'b1;
    wait_sig(0, 1'b0, 10, "ar_rst", n);
    check_int("ar_rst_len", n, 4);
    wait_sig(1, 1'b1, 40, "ar_run", n);
    check_vec("ar_run_out", dut_out(), outv(0, 1, 1, 0, 0, 8'd0));

    // Randomized LOCKED runs and clear pulses against the model.
    reset_n  = 1'b0;
    locked_i = 1'b0;
    clear_i  = 1'b0;
    tick();
    reset_n = 1'b1;
    m_reset();
    lk       = 0;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        lk = !lk;
        if (lk) run_left = int'($urandom_range(5, 60));
        else if ($urandom_range(0, 3) == 0) run_left = int'($urandom_range(40, 100));
        else run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      clr      = ($urandom_range(0, 39) == 0);
      locked_i = lk;
      clear_i  = clr;
      m_step(lk, clr);
      tick();
      check_vec($sformatf("rand_c%0d", c), dut_out(), m_out());
    end
    clear_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
